// File: rtl/ara_apb_uart_tx_if.sv
// APB slave bus bundle for the UART transmitter; signal names follow the block's port list.
`timescale 1ns/1ps
interface ara_apb_uart_tx_if;
    logic        psel_i;
    logic        penable_i;
    logic        pwrite_i;
    logic [31:0] paddr_i;
    logic [31:0] pwdata_i;
    logic [31:0] prdata_o;
    logic        pready_o;
    logic        pslverr_o;

    modport slave (
        input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
        output prdata_o, pready_o, pslverr_o
    );

    modport master (
        output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
        input  prdata_o, pready_o, pslverr_o
    );
endinterface

// File: rtl/ara_apb_uart_tx.sv
// APB-programmed 8N1 UART transmitter with a TX FIFO; one APB wait state, frames of 10*max(DIV,1) cycles.
// THR writes to a full FIFO are refused with pslverr unless the serializer pops on that same edge.
`timescale 1ns/1ps
module ara_apb_uart_tx #(
    parameter int          FifoDepth  = 8,
    parameter logic [15:0] DefaultDiv = 16'd16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    ara_apb_uart_tx_if.slave  apb,
    output logic              tx_o,
    output logic              irq_o
);
    localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int LvlW = PtrW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state;
    logic [15:0]     cnt;
    logic [15:0]     div_lat;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic [15:0]     div;
    logic [7:0]      mem [FifoDepth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [LvlW-1:0] level;

    logic        full, empty, busy, bit_end, pop, push, access, thr_ok;
    logic [1:0]  addr_sel;
    logic [15:0] div_eff;
    logic [6:0]  level_ext;
    logic [31:0] status;
    logic        unused_bits;

    assign full      = (level == LvlW'(FifoDepth));
    assign empty     = (level == '0);
    assign busy      = (state != IDLE);
    assign irq_o     = empty & ~busy;
    assign bit_end   = (cnt == div_lat - 16'd1);
    assign pop       = ~empty & ((state == IDLE) | ((state == STOP) & bit_end));
    assign access    = apb.psel_i & apb.penable_i & ~apb.pready_o;
    assign addr_sel  = apb.paddr_i[3:2];
    // A full FIFO still takes the byte when the serializer drains one on the same edge.
    assign thr_ok    = ~full | pop;
    assign push      = access & apb.pwrite_i & (addr_sel == 2'd0) & thr_ok;
    assign div_eff   = (div == 16'd0) ? 16'd1 : div;
    assign level_ext = 7'(level);
    assign status    = {22'd0, level_ext, busy, empty, full};
    assign unused_bits = ^{apb.paddr_i[31:4], apb.paddr_i[1:0], apb.pwdata_i[31:16]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            apb.pready_o  <= 1'b0;
            apb.prdata_o  <= '0;
            apb.pslverr_o <= 1'b0;
            div           <= DefaultDiv;
        end else begin
            apb.pready_o  <= access;
            apb.prdata_o  <= '0;
            apb.pslverr_o <= 1'b0;
            if (access) begin
                unique case (addr_sel)
                    2'd0: if (!apb.pwrite_i || !thr_ok) apb.pslverr_o <= 1'b1;
                    2'd1: begin
                        if (apb.pwrite_i) apb.pslverr_o <= 1'b1;
                        else              apb.prdata_o  <= status;
                    end
                    2'd2: begin
                        if (apb.pwrite_i) div          <= apb.pwdata_i[15:0];
                        else              apb.prdata_o <= {16'd0, div};
                    end
                    default: apb.pslverr_o <= 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= apb.pwdata_i[7:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PtrW'(1);
            if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
            if (push && !pop)      level <= level + LvlW'(1);
            else if (pop && !push) level <= level - LvlW'(1);
        end
    end

    // The divisor is latched when a byte is popped, so DIV writes only affect later frames.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            tx_o    <= 1'b1;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            div_lat <= 16'd1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        shreg   <= mem[rd_ptr];
                        div_lat <= div_eff;
                        cnt     <= '0;
                        tx_o    <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        tx_o    <= shreg[0];
                        state   <= DATA;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            tx_o  <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shreg   <= shreg >> 1;
                            tx_o    <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (pop) begin
                            shreg   <= mem[rd_ptr];
                            div_lat <= div_eff;
                            tx_o    <= 1'b0;
                            state   <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ara_apb_uart_tx.sv
// Scoreboard bench: stimulus queues expected APB responses and UART frames, monitors check them.
`timescale 1ns/1ps
module tb_ara_apb_uart_tx;
    localparam int Depth = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx, irq;

    ara_apb_uart_tx_if bus();

    ara_apb_uart_tx #(.FifoDepth(Depth), .DefaultDiv(16'd16)) dut (
        .clk_i(clk), .rst_i(rst), .apb(bus), .tx_o(tx), .irq_o(irq)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] b; int per; } frame_t;
    typedef struct { logic [31:0] d; logic e; } rsp_t;

    frame_t exp_frames[$];
    rsp_t   exp_rsp[$];
    int     start_cyc[$];
    int     n_chk = 0;
    int     n_fail = 0;
    int     cyc = 0;
    bit     mon_en = 0;
    bit     in_frame = 0;
    int     div_model = 16;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int period(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // APB response monitor
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (bus.pready_o === 1'b1) begin
                    if (exp_rsp.size() == 0) fail("unexpected_pready");
                    else begin
                        r = exp_rsp.pop_front();
                        chk("apb_prdata", bus.prdata_o, r.d);
                        chk("apb_pslverr", {31'd0, bus.pslverr_o}, {31'd0, r.e});
                    end
                end else begin
                    chk("apb_idle_zero", bus.prdata_o | {31'd0, bus.pslverr_o}, 32'd0);
                end
            end
        end
    end

    // UART line monitor: samples every cycle of a frame against the expected waveform
    initial begin
        frame_t     f;
        int         errs;
        bit         aborted;
        logic [7:0] got;
        int         bitn;
        logic       expb;
        forever begin
            @(negedge clk);
            if (mon_en && !rst && tx === 1'b0) begin
                if (exp_frames.size() == 0) begin
                    fail("unexpected_frame");
                    while (tx !== 1'b1) @(negedge clk);
                end else begin
                    f = exp_frames.pop_front();
                    in_frame = 1;
                    start_cyc.push_back(cyc);
                    errs = 0;
                    aborted = 0;
                    got = '0;
                    for (int c = 0; c < 10 * f.per; c++) begin
                        if (c > 0) @(negedge clk);
                        if (rst) begin
                            aborted = 1;
                            break;
                        end
                        bitn = c / f.per;
                        expb = (bitn == 0) ? 1'b0 : (bitn == 9) ? 1'b1 : f.b[bitn-1];
                        if (tx !== expb) errs++;
                        if (bitn >= 1 && bitn <= 8 && (c % f.per) == f.per / 2) got[bitn-1] = tx;
                    end
                    if (!aborted) begin
                        chk("frame_byte", {24'd0, got}, {24'd0, f.b});
                        chk("frame_wave_errs", errs, 0);
                    end
                    in_frame = 0;
                end
            end
        end
    end

    task automatic apb(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_d, input bit exp_e);
        int k;
        exp_rsp.push_back(rsp_t'{exp_d, exp_e});
        @(posedge clk); #1;
        bus.psel_i = 1'b1; bus.penable_i = 1'b0; bus.pwrite_i = wr;
        bus.paddr_i = addr; bus.pwdata_i = wdata;
        @(posedge clk); #1;
        bus.penable_i = 1'b1;
        @(posedge clk); #1;
        chk("pready_latency", {31'd0, bus.pready_o}, 32'd1);
        k = 0;
        while (bus.pready_o !== 1'b1 && k < 8) begin
            @(posedge clk); #1;
            k++;
        end
        if (bus.pready_o !== 1'b1) begin
            fail("apb_timeout");
            exp_rsp.delete();
        end
        bus.psel_i = 1'b0; bus.penable_i = 1'b0;
    endtask

    task automatic thr(input logic [7:0] b, input bit acc);
        logic [31:0] r;
        r = $urandom;
        if (acc) exp_frames.push_back(frame_t'{b, period(div_model)});
        apb(1'b1, 32'h0, {r[31:8], b}, 32'd0, !acc);
    endtask

    task automatic set_div(input logic [31:0] v);
        apb(1'b1, 32'h8, v, 32'd0, 1'b0);
        div_model = int'(v[15:0]);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
        apb(1'b0, addr, $urandom, exp, 1'b0);
    endtask

    task automatic wait_drain(input int limit);
        int k;
        k = 0;
        while (!(exp_frames.size() == 0 && !in_frame && irq === 1'b1) && k < limit) begin
            @(posedge clk); #1;
            k++;
        end
        chk("drain_in_time", {31'd0, k < limit}, 32'd1);
    endtask

    task automatic wait_start(input int n);
        int k;
        k = 0;
        while (start_cyc.size() <= n && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        chk("frame_started", {31'd0, start_cyc.size() > n}, 32'd1);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_frames.delete();
        @(posedge clk); #1;
        chk("tx_after_reset_edge", {31'd0, tx}, 32'd1);
        chk("pready_in_reset", {31'd0, bus.pready_o}, 32'd0);
        repeat (n - 1) @(posedge clk);
        #1;
        rst = 1'b0;
        div_model = 16;
        @(posedge clk); #1;
        chk("irq_after_reset", {31'd0, irq}, 32'd1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog_timeout (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r1, r2;
        int op, k, n;
        bus.psel_i = 1'b0; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0;
        bus.paddr_i = '0; bus.pwdata_i = '0;

        // reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_tx", {31'd0, tx}, 32'd1);
        chk("reset_pready", {31'd0, bus.pready_o}, 32'd0);
        chk("reset_irq", {31'd0, irq}, 32'd1);
        rst = 1'b0;
        mon_en = 1;
        rd(32'h4, 32'h2);
        rd(32'h8, 32'd16);

        // one frame
        set_div(32'd4);
        thr(8'hA5, 1'b1);
        chk("irq_low_while_pending", {31'd0, irq}, 32'd0);
        wait_drain(200);

        // back-to-back
        start_cyc.delete();
        set_div(32'd1);
        thr(8'h00, 1'b1);
        thr(8'hFF, 1'b1);
        wait_drain(200);
        chk("b2b_frames", start_cyc.size(), 2);
        if (start_cyc.size() >= 2) chk("b2b_gap", start_cyc[1] - start_cyc[0], 10);

        // DIV change mid-frame
        start_cyc.delete();
        set_div(32'd8);
        thr(8'h96, 1'b1);
        wait_start(0);
        repeat (20) @(posedge clk);
        set_div(32'd2);
        thr(8'h4B, 1'b1);
        wait_drain(400);
        chk("divchg_frames", start_cyc.size(), 2);
        if (start_cyc.size() >= 2) chk("divchg_first_len", start_cyc[1] - start_cyc[0], 80);

        // overflow
        set_div(32'd100);
        for (int i = 0; i < Depth + 1; i++) thr(8'(8'h10 + i), 1'b1);
        thr(8'hEE, 1'b0);
        rd(32'h4, 32'h45);
        do_reset(2);
        rd(32'h4, 32'h2);
        rd(32'h8, 32'd16);

        // reset mid-frame
        start_cyc.delete();
        set_div(32'd8);
        thr(8'h3C, 1'b1);
        thr(8'h5A, 1'b1);
        wait_start(0);
        repeat (20) @(posedge clk);
        do_reset(1);
        rd(32'h4, 32'h2);
        n = start_cyc.size();
        repeat (300) @(posedge clk);
        #1;
        chk("no_frame_after_reset", start_cyc.size(), n);

        // randomized mix
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 6);
            r1 = $urandom;
            r2 = $urandom;
            case (op)
                0: set_div({r1[31:16], 16'($urandom_range(0, 5))});
                1: begin
                    k = $urandom_range(1, 4);
                    for (int j = 0; j < k; j++) thr(r2[8*j +: 8], 1'b1);
                    wait_drain(10 * period(div_model) * k + 100);
                end
                2: rd({r1[31:4], 2'b01, r1[1:0]}, 32'h2);
                3: rd({r1[31:4], 2'b10, r1[1:0]}, 32'(div_model));
                4: apb(r2[0], {r1[31:4], 2'b11, r1[1:0]}, r2, 32'd0, 1'b1);
                5: apb(1'b0, {r1[31:4], 2'b00, r1[1:0]}, r2, 32'd0, 1'b1);
                default: apb(1'b1, {r1[31:4], 2'b01, r1[1:0]}, r2, 32'd0, 1'b1);
            endcase
        end

        wait_drain(500);
        repeat (4) @(posedge clk);
        #1;
        chk("rsp_queue_empty", exp_rsp.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
